// File: rtl/phase_measure_pkg.sv
// phase_measure_pkg: dprintf format constants, handshake state and measurement response types.
package phase_measure_pkg;
  localparam logic [31:0] HEX32_PREFIX = 32'h2020_2087;
  localparam logic [63:0] PAD = 64'hffff_ffff_ffff_ffff;
  typedef enum logic {IDLE, PENDING} state_t;
  typedef struct packed {
    logic abort;
    logic initial_value;
    logic [8:0] delay;
    logic [8:0] initial_delay;
  } meas_resp_t;
endpackage

// File: rtl/phase_minmax_tracker.sv
// phase_minmax_tracker: running min/max of delay samples; next_* expose the post-update values.
module phase_minmax_tracker (
  input  logic       clk,
  input  logic       clk__enable,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [8:0] sample,
  output logic [8:0] min,
  output logic [8:0] max,
  output logic [8:0] next_min,
  output logic [8:0] next_max
);
  assign next_min = clear ? 9'h1ff : (sample_valid && sample < min) ? sample : min;
  assign next_max = clear ? 9'h000 : (sample_valid && sample > max) ? sample : max;
  always_ff @(posedge clk)
    if (!reset_n) begin
      min <= 9'h1ff;
      max <= 9'h000;
    end else if (clk__enable) begin
      min <= next_min;
      max <= next_max;
    end
endmodule

// File: rtl/phase_measure_reporter.sv
// phase_measure_reporter: decimates phase measurements into dprintf requests with abort/drop stats.
// Define PHASE_REPORT_MINMAX_EN to track min/max delay into data_1 (otherwise data_1 is all ones).
module phase_measure_reporter
  import phase_measure_pkg::*;
#(
  parameter logic [15:0] DPRINTF_ADDRESS = 16'd80,
  parameter int          DECIMATE        = 16
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        measure_response__valid,
  input  logic        measure_response__abort,
  input  logic        measure_response__initial_value,
  input  logic [8:0]  measure_response__delay,
  input  logic [8:0]  measure_response__initial_delay,
  input  logic        stats_clear,
  output logic        dprintf_req__valid,
  output logic [15:0] dprintf_req__address,
  output logic [63:0] dprintf_req__data_0,
  output logic [63:0] dprintf_req__data_1,
  output logic [63:0] dprintf_req__data_2,
  output logic [63:0] dprintf_req__data_3,
  input  logic        dprintf_ack,
  output logic [7:0]  dropped_count
);
  meas_resp_t resp;
  state_t state, state_next;
  logic [7:0] dec_count, abort_count, abort_next;
  logic trigger, load, drop;
  logic [63:0] data_1_next;
  assign resp = '{abort: measure_response__abort, initial_value: measure_response__initial_value,
                  delay: measure_response__delay, initial_delay: measure_response__initial_delay};
  assign trigger = measure_response__valid && dec_count == 8'(DECIMATE - 1);
  assign abort_next = stats_clear ? 8'h00 :
                      (measure_response__valid && resp.abort && abort_count != 8'hff) ? abort_count + 8'd1 :
                      abort_count;
`ifdef PHASE_REPORT_MINMAX_EN
  logic [8:0] next_min, next_max;
  phase_minmax_tracker u_minmax (
    .clk          (clk),
    .clk__enable  (clk__enable),
    .reset_n      (reset_n),
    .clear        (stats_clear),
    .sample_valid (measure_response__valid && !resp.abort),
    .sample       (resp.delay),
    .min          (),
    .max          (),
    .next_min     (next_min),
    .next_max     (next_max)
  );
  assign data_1_next = {HEX32_PREFIX, 7'h0, next_min, 7'h0, next_max};
`else
  assign data_1_next = PAD;
`endif
  // A trigger while pending replaces the request only if the old one is acked this cycle.
  always_comb begin
    state_next = state;
    load = 1'b0;
    drop = 1'b0;
    if (trigger) begin
      load = state == IDLE || dprintf_ack;
      drop = !load;
      state_next = PENDING;
    end else if (dprintf_ack) state_next = IDLE;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      dec_count <= 8'h00;
      abort_count <= 8'h00;
      dropped_count <= 8'h00;
      dprintf_req__data_0 <= PAD;
      dprintf_req__data_1 <= PAD;
      dprintf_req__data_2 <= PAD;
    end else if (clk__enable) begin
      state <= state_next;
      dec_count <= !measure_response__valid ? dec_count : trigger ? 8'h00 : dec_count + 8'd1;
      abort_count <= abort_next;
      if (drop && dropped_count != 8'hff) dropped_count <= dropped_count + 8'd1;
      if (load) begin
        dprintf_req__data_0 <= {HEX32_PREFIX, 7'h0, resp.initial_delay, 3'h0, resp.delay,
                                1'b0, resp.initial_value, resp.abort, 1'b1};
        dprintf_req__data_1 <= data_1_next;
        dprintf_req__data_2 <= {HEX32_PREFIX, 16'h0, abort_next, dropped_count};
      end
    end
  assign dprintf_req__valid = state == PENDING;
  assign dprintf_req__address = DPRINTF_ADDRESS;
  assign dprintf_req__data_3 = PAD;
endmodule

// File: tb/tb_phase_measure_reporter.sv
// tb_phase_measure_reporter: three DUTs (DECIMATE 4, 1, 3) on shared stimulus against a behavioural model.
module tb_phase_measure_reporter;
  localparam logic [31:0] PFX = 32'h2020_2087;
  localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic en, rst_n, v, ab, iv, clr;
  logic [8:0] dly, idly;
  logic ack [3];
  logic ov [3];
  logic [15:0] oaddr [3];
  logic [63:0] od0 [3], od1 [3], od2 [3], od3 [3];
  logic [7:0] odrop [3];
  int checks = 0, failures = 0;
  int s_min, s_max, s_abort;
  int m_n [3], m_drop [3];
  bit m_pend [3];
  logic [63:0] m_d0 [3], m_d1 [3], m_d2 [3];

  function automatic int dec(input int k);
    return k == 0 ? 4 : k == 1 ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    phase_measure_reporter #(.DPRINTF_ADDRESS(16'd80), .DECIMATE(g == 0 ? 4 : (g == 1 ? 1 : 3))) u_dut (
      .clk                             (clk),
      .clk__enable                     (en),
      .reset_n                         (rst_n),
      .measure_response__valid         (v),
      .measure_response__abort         (ab),
      .measure_response__initial_value (iv),
      .measure_response__delay         (dly),
      .measure_response__initial_delay (idly),
      .stats_clear                     (clr),
      .dprintf_req__valid              (ov[g]),
      .dprintf_req__address            (oaddr[g]),
      .dprintf_req__data_0             (od0[g]),
      .dprintf_req__data_1             (od1[g]),
      .dprintf_req__data_2             (od2[g]),
      .dprintf_req__data_3             (od3[g]),
      .dprintf_ack                     (ack[g]),
      .dropped_count                   (odrop[g])
    );
  end

  // Advance the model with the inputs about to be sampled, then clock and settle.
  task automatic step();
    bit trig;
    if (!rst_n) begin
      s_min = 511; s_max = 0; s_abort = 0;
      for (int k = 0; k < 3; k++) begin
        m_n[k] = 0; m_drop[k] = 0; m_pend[k] = 0;
        m_d0[k] = ONES; m_d1[k] = ONES; m_d2[k] = ONES;
      end
    end else if (en) begin
      if (clr) begin
        s_min = 511; s_max = 0; s_abort = 0;
      end else if (v) begin
        if (ab) s_abort = s_abort < 255 ? s_abort + 1 : 255;
        else begin
          if (int'(dly) < s_min) s_min = int'(dly);
          if (int'(dly) > s_max) s_max = int'(dly);
        end
      end
      for (int k = 0; k < 3; k++) begin
        trig = 0;
        if (v) begin
          m_n[k]++;
          trig = (m_n[k] % dec(k)) == 0;
        end
        if (trig && (!m_pend[k] || ack[k])) begin
          m_pend[k] = 1;
          m_d0[k] = {PFX, 7'h0, idly, 3'h0, dly, 1'b0, iv, ab, 1'b1};
`ifdef PHASE_REPORT_MINMAX_EN
          m_d1[k] = {PFX, 7'h0, 9'(s_min), 7'h0, 9'(s_max)};
`else
          m_d1[k] = ONES;
`endif
          m_d2[k] = {PFX, 16'h0, 8'(s_abort), 8'(m_drop[k])};
        end else if (trig) m_drop[k] = m_drop[k] < 255 ? m_drop[k] + 1 : 255;
        else if (ack[k]) m_pend[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; en = 1; v = 0; ab = 0; clr = 0; iv = 0; dly = 0; idly = 0;
    for (int k = 0; k < 3; k++) ack[k] = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic pulse(input logic [8:0] d, input logic a);
    v = 1; dly = d; ab = a; iv = 1'($urandom); idly = 9'($urandom);
    step();
    v = 0; ab = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], od0[k], od1[k], od2[k], od3[k], odrop[k]} !== {1'b0, ONES, ONES, ONES, ONES, 8'h00}) begin
        failures++;
        $display("FAIL reset dut%0d: valid=%b d0=%h d1=%h d2=%h d3=%h drop=%0d, want idle/all ones/0",
                 k, ov[k], od0[k], od1[k], od2[k], od3[k], odrop[k]);
      end
      checks++;
      if (oaddr[k] !== 16'd80) begin
        failures++;
        $display("FAIL address dut%0d: got %0d want 80", k, oaddr[k]);
      end
    end
  endtask

  task automatic test_decimate();
    logic [8:0] got [$];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (ov[0]) got.push_back(od0[0][12:4]);
        ack[0] = ov[0];
        if (s == 0 && i < 8) pulse(9'h40 + 9'(i), 1'b0);
        else step();
      end
    end
    ack[0] = 0;
    checks++;
    if (got.size() != 2) begin
      failures++;
      $display("FAIL decimate count: got %0d requests want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 9'h43) begin
        failures++;
        $display("FAIL decimate first: delay %h want 043", got[0]);
      end
      checks++;
      if (got[1] !== 9'h47) begin
        failures++;
        $display("FAIL decimate second: delay %h want 047", got[1]);
      end
    end
    checks++;
    if (odrop[0] !== 8'h00 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL decimate end: drop=%0d valid=%b want 0/0", odrop[0], ov[0]);
    end
  endtask

  task automatic test_drop();
    do_reset();
    pulse(9'h11, 1'b0);
    pulse(9'h22, 1'b0);
    pulse(9'h33, 1'b0);
    checks++;
    if ({ov[1], od0[1][12:4], odrop[1]} !== {1'b1, 9'h11, 8'd2}) begin
      failures++;
      $display("FAIL drop: valid=%b delay=%h drop=%0d want 1/011/2", ov[1], od0[1][12:4], odrop[1]);
    end
    ack[1] = 1;
    step();
    ack[1] = 0;
    checks++;
    if (ov[1] !== 1'b0) begin
      failures++;
      $display("FAIL drop ack: valid=%b want 0", ov[1]);
    end
    step();
    checks++;
    if (ov[1] !== 1'b0 || odrop[1] !== 8'd2) begin
      failures++;
      $display("FAIL drop hold: valid=%b drop=%0d want 0/2", ov[1], odrop[1]);
    end
  endtask

  task automatic test_minmax();
    logic [63:0] want1;
    do_reset();
    pulse(9'h10, 1'b0);
    pulse(9'h80, 1'b0);
    pulse(9'h05, 1'b1);
`ifdef PHASE_REPORT_MINMAX_EN
    want1 = {PFX, 7'h0, 9'h010, 7'h0, 9'h080};
`else
    want1 = ONES;
`endif
    checks++;
    if (ov[2] !== 1'b1 || od1[2] !== want1) begin
      failures++;
      $display("FAIL minmax: valid=%b d1=%h want 1/%h", ov[2], od1[2], want1);
    end
    checks++;
    if (od2[2] !== {PFX, 16'h0, 8'd1, 8'd0} || od0[2][1] !== 1'b1) begin
      failures++;
      $display("FAIL abort count: d2=%h abort_bit=%b want %h/1", od2[2], od0[2][1], {PFX, 16'h0, 8'd1, 8'd0});
    end
  endtask

  task automatic test_clear();
    logic [63:0] want1;
    do_reset();
    ack[1] = 1;
    pulse(9'h50, 1'b0);
    pulse(9'h07, 1'b1);
    clr = 1;
    pulse(9'h02, 1'b0);
    clr = 0;
    pulse(9'h30, 1'b0);
    ack[1] = 0;
`ifdef PHASE_REPORT_MINMAX_EN
    want1 = {PFX, 7'h0, 9'h030, 7'h0, 9'h030};
`else
    want1 = ONES;
`endif
    checks++;
    if (od1[1] !== want1 || od2[1][15:8] !== 8'd0) begin
      failures++;
      $display("FAIL clear: d1=%h abort=%0d want %h/0", od1[1], od2[1][15:8], want1);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    pulse(9'h21, 1'b1);
    pulse(9'h22, 1'b0);
    checks++;
    if (ov[1] !== 1'b1 || odrop[1] !== 8'd1) begin
      failures++;
      $display("FAIL pre-reset: valid=%b drop=%0d want 1/1", ov[1], odrop[1]);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], od0[k], od1[k], od2[k], odrop[k]} !== {1'b0, ONES, ONES, ONES, 8'h00}) begin
        failures++;
        $display("FAIL reset pending dut%0d: valid=%b d0=%h d2=%h drop=%0d want 0/ones/0",
                 k, ov[k], od0[k], od2[k], odrop[k]);
      end
    end
    pulse(9'h44, 1'b0);
    checks++;
    if (od2[1] !== {PFX, 32'h0}) begin
      failures++;
      $display("FAIL post-reset counters: d2=%h want %h", od2[1], {PFX, 32'h0});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 5) != 0;
      v = ($urandom % 3) == 0;
      ab = ($urandom % 4) == 0;
      clr = ($urandom % 16) == 0;
      iv = 1'($urandom);
      dly = 9'($urandom);
      idly = 9'($urandom);
      for (int k = 0; k < 3; k++) ack[k] = ($urandom % 3) == 0;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({ov[k], od0[k], od1[k], od2[k], od3[k], odrop[k]} !==
            {m_pend[k], m_d0[k], m_d1[k], m_d2[k], ONES, 8'(m_drop[k])}) begin
          failures++;
          $display("FAIL random dut%0d cycle %0d: got v=%b d0=%h d1=%h d2=%h d3=%h drop=%0d want v=%b d0=%h d1=%h d2=%h drop=%0d",
                   k, i, ov[k], od0[k], od1[k], od2[k], od3[k], odrop[k],
                   m_pend[k], m_d0[k], m_d1[k], m_d2[k], m_drop[k]);
        end
      end
    end
    en = 1; v = 0; clr = 0;
    for (int k = 0; k < 3; k++) ack[k] = 0;
  endtask

  initial begin
    test_reset();
    test_decimate();
    test_drop();
    test_minmax();
    test_clear();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
